uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_WORD_SIZE, default 8, meaning the receiver word width in bits.
REQ-002 The block SHALL have parameter DATA_BYTES, default 4, meaning the number of payload bytes per command frame.
REQ-003 The block SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame start marker.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of clk cycles allowed between bytes inside a frame.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port rx_dout, input, MAX_WORD_SIZE bits: received word from the UART receiver; only bits [7:0] are used.
REQ-008 The block SHALL have port rx_done, input, 1 bit: one-cycle pulse marking rx_dout valid.
REQ-009 The block SHALL have port rx_bits, output, 6 bits: word-length configuration driven to the UART receiver.
REQ-010 The block SHALL have port reg_addr, output, 8 bits: register address of the decoded command.
REQ-011 The block SHALL have port reg_wdata, output, 8*DATA_BYTES bits: command payload, first received data byte in the MSBs.
REQ-012 The block SHALL have port reg_valid, output, 1 bit: write request to the register bank.
REQ-013 The block SHALL have port reg_ready, input, 1 bit: register bank accepts the write.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 The block SHALL have port err_csum, output, 1 bit: one-cycle pulse on checksum mismatch.
REQ-016 The block SHALL have port err_timeout, output, 1 bit: one-cycle pulse on an inter-byte timeout.
REQ-017 The block SHALL have port err_overrun, output, 1 bit: one-cycle pulse when a byte arrives in state ISSUE.
REQ-018 The block SHALL have port frame_count, output, 16 bits: count of frames accepted by the register bank.

Function
REQ-019 The frame format SHALL be SYNC_BYTE, ADDR, D0..D(DATA_BYTES-1), CSUM, where CSUM = XOR of ADDR and all data bytes.
REQ-020 The FSM SHALL have states IDLE, ADDR, DATA, CSUM and ISSUE; every transition SHALL be qualified by rx_done except ISSUE->IDLE and timeout exits.
REQ-021 In IDLE, a byte equal to SYNC_BYTE SHALL move the FSM to ADDR; any other byte SHALL be ignored without raising an error.
REQ-022 In ADDR, the received byte SHALL be latched to reg_addr and seed the running checksum, and the FSM SHALL move to DATA with the byte index set to 0.
REQ-023 In DATA, each byte SHALL be shifted into reg_wdata and XORed into the checksum; when index DATA_BYTES-1 is received, the FSM SHALL move to CSUM.
REQ-024 In CSUM, on a checksum match the FSM SHALL enter ISSUE, and reg_valid SHALL be high on the cycle after the checksum byte's rx_done.
REQ-025 In CSUM, on a checksum mismatch err_csum SHALL pulse on the cycle after the checksum byte's rx_done, the FSM SHALL return to IDLE, and reg_valid SHALL NOT assert.
REQ-026 In ISSUE, reg_valid, reg_addr and reg_wdata SHALL be held stable until the cycle in which reg_ready=1.
  - In that cycle the FSM SHALL go to IDLE and frame_count SHALL increment, wrapping from 16'hFFFF to 0.
  - reg_valid SHALL be low in the following cycle.
REQ-027 A rx_done in ISSUE SHALL drop the byte and pulse err_overrun on the next cycle, with no state change.
REQ-028 An inter-byte cycle counter SHALL clear on every accepted rx_done and on entry to ADDR, and SHALL count in the ADDR, DATA and CSUM states.
  - When it reaches TIMEOUT_CYCLES-1, err_timeout SHALL pulse and the FSM SHALL return to IDLE, discarding the partial frame.
REQ-029 When rx_done coincides with timeout expiry, the byte SHALL be accepted and the timeout SHALL NOT fire.
REQ-030 There SHALL be no timeout in IDLE or ISSUE.
REQ-031 rx_bits SHALL be driven constant at 8.
REQ-032 The checksum and the byte index SHALL be cleared on entry to ADDR.
REQ-033 No more than one error pulse SHALL assert per cycle.

Reset
REQ-034 When rst=1 at a clk edge, the block SHALL set:
  - state to IDLE;
  - reg_valid, busy, err_csum, err_timeout and err_overrun to 0;
  - reg_addr, reg_wdata and frame_count to 0;
  - rx_bits to 8;
  - counter, index and checksum to 0.
REQ-035 Reset asserted mid-frame or during ISSUE SHALL discard the frame, and no write SHALL occur.
REQ-036 rx_done SHALL be ignored in any cycle where rst=1.

Verification
REQ-037 Good frame: bytes A5,10,DE,AD,BE,EF,32 with reg_ready=1 -> reg_valid for 1 cycle, reg_addr=8'h10, reg_wdata=32'hDEADBEEF, frame_count=1.
REQ-038 Bad checksum: the same frame with CSUM=33 -> err_csum pulses once, no reg_valid, frame_count unchanged, busy=0 afterwards.
REQ-039 Timeout: A5,10,DE, then 1024 idle cycles -> err_timeout pulses exactly once, FSM returns to IDLE; a following good frame is accepted correctly.
REQ-040 Backpressure and overrun: good frame with reg_ready=0 for 20 cycles plus one rx_done in ISSUE -> err_overrun pulses once, reg_valid and data stay stable for 20 cycles, a single write on reg_ready.
REQ-041 Noise and reset: bytes 00,FF before A5 are ignored; rst asserted after the ADDR byte -> all outputs return to reset values and no write occurs.
REQ-042 Counter wrap: preload 65535 accepted frames, then one more -> frame_count=0.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Purpose:
//   Decodes framed write commands arriving byte-by-byte from a UART receiver
//   and issues them as single write requests to a register bank.
//   Frame layout: SYNC_BYTE, ADDR, D0 .. D(DATA_BYTES-1), CSUM, where CSUM is
//   the XOR of ADDR and every data byte. A frame is abandoned on a checksum
//   mismatch or when the gap between two bytes inside a frame runs too long.
//
// Ports:
//   clk          in   single clock for all logic
//   rst          in   synchronous, active-high reset
//   rx_dout      in   received word (only bits [7:0] are used)
//   rx_done      in   one-cycle strobe, rx_dout valid
//   rx_bits      out  receiver word-length setting, fixed at 8
//   reg_addr     out  register address of the decoded command
//   reg_wdata    out  payload, first data byte in the MSBs
//   reg_valid    out  write request to the register bank
//   reg_ready    in   register bank accepts the write
//   busy         out  high while a frame is in progress or being issued
//   err_csum     out  one-cycle pulse, checksum mismatch
//   err_timeout  out  one-cycle pulse, inter-byte timeout
//   err_overrun  out  one-cycle pulse, byte received while a write is pending
//   frame_count  out  number of writes accepted by the register bank (wraps)
// -----------------------------------------------------------------------------
module uart_cmd_ctrl #(
  parameter int         MAX_WORD_SIZE  = 8,
  parameter int         DATA_BYTES     = 4,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MAX_WORD_SIZE-1:0]  rx_dout,
  input  logic                      rx_done,
  output logic [5:0]                rx_bits,
  output logic [7:0]                reg_addr,
  output logic [8*DATA_BYTES-1:0]   reg_wdata,
  output logic                      reg_valid,
  input  logic                      reg_ready,
  output logic                      busy,
  output logic                      err_csum,
  output logic                      err_timeout,
  output logic                      err_overrun,
  output logic [15:0]               frame_count
);

  localparam int WD_W  = 8 * DATA_BYTES;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CSUM,
    ST_ISSUE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [7:0]        csum;
  logic [7:0]        csum_nxt;
  logic [7:0]        addr_nxt;
  logic [WD_W-1:0]   wdata_nxt;
  logic [15:0]       fcnt_nxt;
  logic              err_csum_nxt;
  logic              err_timeout_nxt;
  logic              err_overrun_nxt;
  logic [7:0]        rx_byte;
  logic              timed;

  assign rx_byte = rx_dout[7:0];

  // Shift a new byte in at the LSB end so the first byte ends up in the MSBs.
  function automatic logic [WD_W-1:0] shift_in(input logic [WD_W-1:0] cur,
                                               input logic [7:0]      b);
    return WD_W'({cur, b});
  endfunction

  // Timeout supervision only runs while a frame is being collected.
  assign timed = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CSUM);

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    idx_nxt         = idx;
    csum_nxt        = csum;
    addr_nxt        = reg_addr;
    wdata_nxt       = reg_wdata;
    fcnt_nxt        = frame_count;
    err_csum_nxt    = 1'b0;
    err_timeout_nxt = 1'b0;
    err_overrun_nxt = 1'b0;

    // A byte arriving on the expiry cycle wins over the timeout.
    if (timed) begin
      if (rx_done) begin
        cnt_nxt = '0;
      end else if (cnt == CNT_LAST) begin
        err_timeout_nxt = 1'b1;
        state_nxt       = ST_IDLE;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        if (rx_done && (rx_byte == SYNC_BYTE)) begin
          state_nxt = ST_ADDR;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          csum_nxt  = '0;
        end
      end
      ST_ADDR: begin
        if (rx_done) begin
          addr_nxt  = rx_byte;
          csum_nxt  = rx_byte;
          idx_nxt   = '0;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_done) begin
          wdata_nxt = shift_in(reg_wdata, rx_byte);
          csum_nxt  = csum ^ rx_byte;
          if (idx == IDX_LAST) begin
            state_nxt = ST_CSUM;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      ST_CSUM: begin
        if (rx_done) begin
          if (rx_byte == csum) begin
            state_nxt = ST_ISSUE;
          end else begin
            err_csum_nxt = 1'b1;
            state_nxt    = ST_IDLE;
          end
        end
      end
      ST_ISSUE: begin
        // Bytes arriving while the write is pending are dropped.
        if (rx_done) begin
          err_overrun_nxt = 1'b1;
        end
        if (reg_ready) begin
          state_nxt = ST_IDLE;
          fcnt_nxt  = frame_count + 16'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      csum        <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      frame_count <= '0;
      err_csum    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      csum        <= csum_nxt;
      reg_addr    <= addr_nxt;
      reg_wdata   <= wdata_nxt;
      frame_count <= fcnt_nxt;
      err_csum    <= err_csum_nxt;
      err_timeout <= err_timeout_nxt;
      err_overrun <= err_overrun_nxt;
    end
  end

  assign reg_valid = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);
  assign rx_bits   = 6'd8;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
//
// Directed bench for uart_cmd_ctrl with default parameters. Inputs are driven
// and outputs sampled on the falling clock edge; pulse and write events are
// tallied on the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_dout;
  logic        rx_done;
  logic [5:0]  rx_bits;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_valid;
  logic        reg_ready;
  logic        busy;
  logic        err_csum;
  logic        err_timeout;
  logic        err_overrun;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;

  int n_csum = 0;
  int n_tmo  = 0;
  int n_ovr  = 0;
  int n_wr   = 0;

  uart_cmd_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rx_dout     (rx_dout),
    .rx_done     (rx_done),
    .rx_bits     (rx_bits),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_valid   (reg_valid),
    .reg_ready   (reg_ready),
    .busy        (busy),
    .err_csum    (err_csum),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err_csum)               n_csum++;
    if (err_timeout)            n_tmo++;
    if (err_overrun)            n_ovr++;
    if (reg_valid && reg_ready) n_wr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the byte
  // was sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_dout = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    send_byte(c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int w0, c0, t0, o0, stable;

  initial begin
    rst       = 1'b1;
    rx_dout   = 8'h00;
    rx_done   = 1'b0;
    reg_ready = 1'b1;
    idle(3);

    // Reset state
    chk("rst_valid",  32'(reg_valid),   32'd0);
    chk("rst_busy",   32'(busy),        32'd0);
    chk("rst_errs",   32'({err_csum, err_timeout, err_overrun}), 32'd0);
    chk("rst_addr",   32'(reg_addr),    32'd0);
    chk("rst_wdata",  reg_wdata,        32'd0);
    chk("rst_fcnt",   32'(frame_count), 32'd0);
    chk("rst_rxbits", 32'(rx_bits),     32'd8);
    rst = 1'b0;
    idle(2);

    // Good frame, bank always ready
    w0 = n_wr;
    send_frame(8'h10, 32'hDEADBEEF, 8'h32);
    chk("good_valid", 32'(reg_valid), 32'd1);
    chk("good_addr",  32'(reg_addr),  32'h10);
    chk("good_wdata", reg_wdata,      32'hDEADBEEF);
    idle(1);
    chk("good_valid_drop", 32'(reg_valid),   32'd0);
    chk("good_fcnt",       32'(frame_count), 32'd1);
    chk("good_busy",       32'(busy),        32'd0);
    chk("good_writes",     32'(n_wr - w0),   32'd1);

    // Bad checksum
    w0 = n_wr; c0 = n_csum;
    send_frame(8'h10, 32'hDEADBEEF, 8'h33);
    chk("bad_errcsum", 32'(err_csum),  32'd1);
    chk("bad_valid",   32'(reg_valid), 32'd0);
    chk("bad_busy",    32'(busy),      32'd0);
    idle(3);
    chk("bad_csum_pulses", 32'(n_csum - c0), 32'd1);
    chk("bad_writes",      32'(n_wr - w0),   32'd0);
    chk("bad_fcnt",        32'(frame_count), 32'd1);

    // Inter-byte timeout after a partial frame
    t0 = n_tmo;
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'hDE);
    idle(1023);
    chk("tmo_not_yet_busy", 32'(busy),        32'd1);
    chk("tmo_not_yet_err",  32'(err_timeout), 32'd0);
    idle(1);
    chk("tmo_err",  32'(err_timeout), 32'd1);
    chk("tmo_busy", 32'(busy),        32'd0);
    idle(3);
    chk("tmo_pulses", 32'(n_tmo - t0), 32'd1);
    send_frame(8'h10, 32'hDEADBEEF, 8'h32);
    chk("tmo_next_wdata", reg_wdata, 32'hDEADBEEF);
    idle(1);
    chk("tmo_next_fcnt", 32'(frame_count), 32'd2);

    // Byte landing exactly on the expiry cycle is accepted
    t0 = n_tmo;
    send_byte(8'hA5);
    idle(1023);
    send_byte(8'h22);
    chk("edge_busy", 32'(busy), 32'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h26);
    chk("edge_addr",  32'(reg_addr), 32'h22);
    chk("edge_wdata", reg_wdata,     32'h01020304);
    idle(1);
    chk("edge_no_tmo", 32'(n_tmo - t0),   32'd0);
    chk("edge_fcnt",   32'(frame_count),  32'd3);

    // Backpressure with an overrun byte while the write is pending
    reg_ready = 1'b0;
    w0 = n_wr; o0 = n_ovr; stable = 0;
    send_frame(8'h5A, 32'h11223344, 8'h1E);
    for (int i = 0; i < 20; i++) begin
      if (reg_valid && reg_addr == 8'h5A && reg_wdata == 32'h11223344) stable++;
      if (i == 5) begin
        rx_dout = 8'h77;
        rx_done = 1'b1;
      end else begin
        rx_done = 1'b0;
      end
      @(negedge clk);
    end
    rx_done = 1'b0;
    chk("bp_stable_cycles", 32'(stable),       32'd20);
    chk("bp_overrun",       32'(n_ovr - o0),   32'd1);
    chk("bp_no_write_yet",  32'(n_wr - w0),    32'd0);
    chk("bp_wdata_kept",    reg_wdata,         32'h11223344);
    reg_ready = 1'b1;
    chk("bp_valid_at_ready", 32'(reg_valid), 32'd1);
    idle(1);
    chk("bp_valid_drop", 32'(reg_valid),   32'd0);
    chk("bp_writes",     32'(n_wr - w0),   32'd1);
    chk("bp_fcnt",       32'(frame_count), 32'd4);

    // Noise bytes, then reset mid-frame
    w0 = n_wr; c0 = n_csum; t0 = n_tmo; o0 = n_ovr;
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("noise_busy", 32'(busy), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h10);
    chk("noise_in_frame", 32'(busy), 32'd1);
    rst = 1'b1;
    send_byte(8'hA5);
    rst = 1'b0;
    chk("mid_rst_busy",  32'(busy),        32'd0);
    chk("mid_rst_addr",  32'(reg_addr),    32'd0);
    chk("mid_rst_wdata", reg_wdata,        32'd0);
    chk("mid_rst_fcnt",  32'(frame_count), 32'd0);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h32);
    idle(2);
    chk("mid_rst_no_write", 32'(n_wr - w0), 32'd0);
    chk("mid_rst_idle",     32'(busy),      32'd0);
    chk("noise_no_errs",    32'((n_csum - c0) + (n_tmo - t0) + (n_ovr - o0)), 32'd0);

    // Frame counter wrap from a preloaded 16'hFFFF
    force dut.frame_count = 16'hFFFF;
    idle(1);
    release dut.frame_count;
    idle(1);
    chk("wrap_preload", 32'(frame_count), 32'hFFFF);
    send_frame(8'h10, 32'hDEADBEEF, 8'h32);
    idle(1);
    chk("wrap_fcnt", 32'(frame_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
